rs485_poll_master: RTL and testbench

//  Bus-master end of the RS485 poll/response link. On a start pulse it transmits one poll frame,

---
 rtl/rs485_poll_master_if.sv | 45 ++++
 rtl/rs485_poll_master.sv | 265 ++++++++++++++++++++++++++
 tb/tb_rs485_poll_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs485_poll_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : rs485_poll_master_if
//  Brief    : Host/line signal bundle for the RS485 poll master.
//  Revision : 1.0 - initial release
// ============================================================================
interface rs485_poll_master_if;
    logic       start;
    logic       rx;
    logic       tx;
    logic       tx_en;
    logic       busy;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       done;
    logic       timeout_err;
    logic       frame_err;

    modport master (
        input  start,
        input  rx,
        output tx,
        output tx_en,
        output busy,
        output rx_byte,
        output rx_valid,
        output done,
        output timeout_err,
        output frame_err
    );

    modport slave (
        output start,
        output rx,
        input  tx,
        input  tx_en,
        input  busy,
        input  rx_byte,
        input  rx_valid,
        input  done,
        input  timeout_err,
        input  frame_err
    );
endinterface
`default_nettype wire

// File: rtl/rs485_poll_master.sv
`default_nettype none
// ============================================================================
//  Module   : rs485_poll_master
//  Brief    : Sends one poll frame, then collects RESP_BYTES response frames.
//  Revision : 1.0 - initial release
// ============================================================================
module rs485_poll_master #(
    parameter int         CLKS_PER_BIT   = 1,
    parameter logic [7:0] POLL_BYTE      = 8'h01,
    parameter int         RESP_BYTES     = 4,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    rs485_poll_master_if.master bus
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CPB_M1  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF    = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_RX_CNT0 = c_CNT_W'((CLKS_PER_BIT == 1) ? 0 : 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX  = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]         c_RESP    = 8'(RESP_BYTES);
    localparam logic               c_CPB_ONE = (CLKS_PER_BIT == 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_TX_START = 3'd1;
    localparam logic [2:0] c_TX_DATA  = 3'd2;
    localparam logic [2:0] c_TX_STOP  = 3'd3;
    localparam logic [2:0] c_RX_WAIT  = 3'd4;
    localparam logic [2:0] c_RX_START = 3'd5;
    localparam logic [2:0] c_RX_DATA  = 3'd6;
    localparam logic [2:0] c_RX_STOP  = 3'd7;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_rx_meta;
    logic               r_rx_s;

    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [c_CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [c_TO_W-1:0]  w_to_cnt_nxt;
    logic [c_TO_W-1:0]  w_to_inc;
    logic [7:0]         r_byte_cnt;
    logic [7:0]         w_byte_cnt_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;

    logic               r_tx;
    logic               w_tx_nxt;
    logic               r_tx_en;
    logic               w_tx_en_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [7:0]         r_rx_byte;
    logic [7:0]         w_rx_byte_nxt;
    logic               r_rx_valid;
    logic               w_rx_valid_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_timeout_err;
    logic               w_timeout_err_nxt;
    logic               r_frame_err;
    logic               w_frame_err_nxt;

    logic               w_bit_end;
    logic               w_rx_mid;
    logic               w_to_hit;
    logic               w_last_byte;

    assign w_bit_end   = (r_clk_cnt == c_CPB_M1);
    assign w_rx_mid    = (r_clk_cnt == c_HALF);
    assign w_to_inc    = r_to_cnt + 1'b1;
    assign w_to_hit    = (w_to_inc == c_TO_MAX);
    assign w_last_byte = ((r_byte_cnt + 8'd1) == c_RESP);

    // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clk or negedge rst_n) begin : p_rx_sync
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:     if (bus.start) w_state_nxt = c_TX_START;
            c_TX_START: if (w_bit_end) w_state_nxt = c_TX_DATA;
            c_TX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = c_TX_STOP;
            c_TX_STOP:  if (w_bit_end) w_state_nxt = c_RX_WAIT;
            c_RX_WAIT: begin
                // With one clock per bit the detecting cycle is the start bit, so no re-check.
                if (w_to_hit) begin
                    w_state_nxt = c_IDLE;
                end else if (!r_rx_s) begin
                    w_state_nxt = c_CPB_ONE ? c_RX_DATA : c_RX_START;
                end
            end
            c_RX_START: if (w_rx_mid) w_state_nxt = r_rx_s ? c_RX_WAIT : c_RX_DATA;
            c_RX_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = c_RX_STOP;
            c_RX_STOP:  if (w_bit_end) w_state_nxt = (r_rx_s && !w_last_byte) ? c_RX_WAIT : c_IDLE;
            default:    w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        w_clk_cnt_nxt     = r_clk_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_to_cnt_nxt      = r_to_cnt;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_shift_nxt       = r_shift;
        w_busy_nxt        = r_busy;
        w_rx_byte_nxt     = r_rx_byte;
        w_rx_valid_nxt    = 1'b0;
        w_done_nxt        = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_frame_err_nxt   = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_busy_nxt    = 1'b1;
                    w_clk_cnt_nxt = '0;
                end
            end
            c_TX_START, c_TX_DATA, c_TX_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = (r_state == c_TX_DATA) ? (r_bit_idx + 3'd1) : 3'd0;
                    if (r_state == c_TX_STOP) begin
                        w_byte_cnt_nxt = '0;
                        w_to_cnt_nxt   = '0;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            c_RX_WAIT: begin
                if (w_to_hit) begin
                    w_to_cnt_nxt      = '0;
                    w_busy_nxt        = 1'b0;
                    w_done_nxt        = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_to_cnt_nxt = w_to_inc;
                    if (!r_rx_s) begin
                        w_clk_cnt_nxt = c_RX_CNT0;
                        w_bit_idx_nxt = 3'd0;
                    end
                end
            end
            c_RX_START: begin
                // Data sampling then lands CLKS_PER_BIT clocks after this mid-start sample.
                w_clk_cnt_nxt = w_rx_mid ? '0 : (r_clk_cnt + 1'b1);
            end
            c_RX_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            c_RX_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_rx_byte_nxt  = r_shift;
                        w_rx_valid_nxt = 1'b1;
                        w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                        w_to_cnt_nxt   = '0;
                        if (w_last_byte) begin
                            w_done_nxt = 1'b1;
                            w_busy_nxt = 1'b0;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_done_nxt      = 1'b1;
                        w_busy_nxt      = 1'b0;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: ;
        endcase

        // Line outputs follow the upcoming state so they change on the same edge as it.
        w_tx_nxt    = 1'b1;
        w_tx_en_nxt = 1'b0;
        case (w_state_nxt)
            c_TX_START: begin
                w_tx_nxt    = 1'b0;
                w_tx_en_nxt = 1'b1;
            end
            c_TX_DATA: begin
                w_tx_nxt    = POLL_BYTE[w_bit_idx_nxt];
                w_tx_en_nxt = 1'b1;
            end
            c_TX_STOP: w_tx_en_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_data_reg
        if (!rst_n) begin
            r_clk_cnt     <= '0;
            r_bit_idx     <= '0;
            r_to_cnt      <= '0;
            r_byte_cnt    <= '0;
            r_shift       <= '0;
            r_tx          <= 1'b1;
            r_tx_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_rx_byte     <= '0;
            r_rx_valid    <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_clk_cnt     <= w_clk_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_byte_cnt    <= w_byte_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_tx          <= w_tx_nxt;
            r_tx_en       <= w_tx_en_nxt;
            r_busy        <= w_busy_nxt;
            r_rx_byte     <= w_rx_byte_nxt;
            r_rx_valid    <= w_rx_valid_nxt;
            r_done        <= w_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_frame_err   <= w_frame_err_nxt;
        end
    end

    assign bus.tx          = r_tx;
    assign bus.tx_en       = r_tx_en;
    assign bus.busy        = r_busy;
    assign bus.rx_byte     = r_rx_byte;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_rs485_poll_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs485_poll_master
//  Brief    : Directed self-checking bench for rs485_poll_master (1 and 4 clk/bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rs485_poll_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rs485_poll_master_if bus1 ();
    rs485_poll_master_if bus4 ();

    rs485_poll_master #(
        .CLKS_PER_BIT   (1),
        .POLL_BYTE      (8'h01),
        .RESP_BYTES     (4),
        .TIMEOUT_CYCLES (64)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    rs485_poll_master #(
        .CLKS_PER_BIT   (4),
        .POLL_BYTE      (8'h01),
        .RESP_BYTES     (4),
        .TIMEOUT_CYCLES (64)
    ) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] got_q[$];
    int n_done1, n_to1, n_fe1, n_done_valid1;
    int n_valid4, n_done4, n_txen_rise4;
    logic txen4_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        n_done1 = 0; n_to1 = 0; n_fe1 = 0; n_done_valid1 = 0;
        n_valid4 = 0; n_done4 = 0; n_txen_rise4 = 0;
    endtask

    // Outputs are sampled on the falling edge, well away from the active edge.
    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (bus1.rx_valid) got_q.push_back(bus1.rx_byte);
            if (bus1.done) begin
                n_done1++;
                if (bus1.timeout_err) n_to1++;
                if (bus1.frame_err)   n_fe1++;
                if (bus1.rx_valid)    n_done_valid1++;
            end
            if (bus4.rx_valid) n_valid4++;
            if (bus4.done)     n_done4++;
            if (bus4.tx_en && !txen4_prev) n_txen_rise4++;
            txen4_prev = bus4.tx_en;
        end
    end

    // Poll frame for 0x01, index k = bit time: start 0, data 1,0..0, stop 1.
    task automatic send_poll(input string tag);
        logic [9:0] exp_tx;
        exp_tx = 10'b10_0000_0010;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("%s_bit%0d", tag, k), {bus1.busy, bus1.tx_en, bus1.tx},
                  {1'b1, 1'b1, exp_tx[k]});
        end
        @(posedge clk); #1;
        check($sformatf("%s_after", tag), {bus1.busy, bus1.tx_en, bus1.tx}, 3'b101);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bus1.rx = f[k];
            @(posedge clk); #1;
        end
        bus1.rx = 1'b1;
    endtask

    task automatic wait_done1(input int max_cycles);
        int w;
        w = 0;
        while (n_done1 == 0 && w < max_cycles) begin
            @(posedge clk); #1;
            w++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int el;
        int hi;
        logic [7:0] exp_resp [4];
        exp_resp[0] = 8'hA5; exp_resp[1] = 8'h3C; exp_resp[2] = 8'hFF; exp_resp[3] = 8'h00;

        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.rx = 1'b1;
        bus4.start = 1'b0; bus4.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_line1",   {bus1.busy, bus1.tx_en, bus1.tx}, 3'b001);
        check("rst_rx_byte", bus1.rx_byte, 8'h00);
        check("rst_pulses1", {bus1.rx_valid, bus1.done, bus1.timeout_err, bus1.frame_err}, 4'b0000);
        check("rst_line4",   {bus4.busy, bus4.tx_en, bus4.tx}, 3'b001);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Poll frame, then no response: timeout 64 clocks into RX_WAIT.
        clear_mon();
        send_poll("t1_poll");
        check("t3_busy_wait", bus1.busy, 1'b1);
        el = 0;
        while (!bus1.done && el < 200) begin
            @(posedge clk); #1;
            el++;
        end
        check("t3_latency",  el, 64);
        check("t3_flags",    {bus1.timeout_err, bus1.frame_err}, 2'b10);
        check("t3_busy_off", bus1.busy, 1'b0);
        check("t3_no_valid", got_q.size(), 0);
        @(posedge clk); #1;
        check("t3_pulse_end", {bus1.done, bus1.timeout_err}, 2'b00);

        // Four back-to-back response frames.
        clear_mon();
        send_poll("t2_poll");
        for (int i = 0; i < 4; i++) send_frame(exp_resp[i], 1'b1);
        wait_done1(30);
        check("t2_n_bytes", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_byte%0d", i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD_BEEF,
                  exp_resp[i]);
        check("t2_done_cnt",    n_done1, 1);
        check("t2_done_with_4", n_done_valid1, 1);
        check("t2_no_err",      n_to1 + n_fe1, 0);
        check("t2_busy_off",    bus1.busy, 1'b0);
        check("t2_rx_byte",     bus1.rx_byte, 8'h00);

        // Second byte with a low stop bit.
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        send_poll("t4_poll");
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b0);
        wait_done1(30);
        check("t4_n_bytes",  got_q.size(), 1);
        check("t4_byte0",    (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hDEAD_BEEF, 8'h5A);
        check("t4_frame",    n_fe1, 1);
        check("t4_no_to",    n_to1, 0);
        check("t4_done_cnt", n_done1, 1);
        check("t4_rx_hold",  bus1.rx_byte, 8'h5A);
        check("t4_busy_off", bus1.busy, 1'b0);

        // Asynchronous reset in the middle of TX_DATA.
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_pre_txen", bus1.tx_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_line",   {bus1.busy, bus1.tx_en, bus1.tx}, 3'b001);
        check("t5_rst_rxbyte", bus1.rx_byte, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_poll("t5_poll");
        wait_done1(100);
        check("t5_timeout", n_to1, 1);

        // 4 clocks per bit: start while busy, and a 1-clock glitch in RX_WAIT.
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        bus4.start = 1'b1;
        @(posedge clk); #1;
        hi = bus4.tx_en ? 1 : 0;
        for (int c = 1; c < 100 && bus4.tx_en; c++) begin
            bus4.start = (c == 10);
            @(posedge clk); #1;
            if (bus4.tx_en) hi++;
        end
        bus4.start = 1'b0;
        check("t6_txen_len", hi, 40);
        check("t6_tx_idle",  bus4.tx, 1'b1);
        el = 0;
        repeat (20) begin
            @(posedge clk); #1;
            el++;
        end
        bus4.rx = 1'b0;
        @(posedge clk); #1;
        el++;
        bus4.rx = 1'b1;
        while (!bus4.done && el < 200) begin
            @(posedge clk); #1;
            el++;
        end
        check("t6_to_kept", (el >= 64 && el <= 70), 1'b1);
        check("t6_flags",   {bus4.timeout_err, bus4.frame_err}, 2'b10);
        repeat (30) @(posedge clk);
        #1;
        check("t6_single_poll", n_txen_rise4, 1);
        check("t6_no_valid",    n_valid4, 0);
        check("t6_done_cnt",    n_done4, 1);
        check("t6_busy_off",    bus4.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
